cell_alloc: RTL and testbench

Free-list cell allocator that owns the write and read ports of the 256x16 BRAM (bram256x16) and sits directly upstream of it. It accepts alloc/free requests, hands out cell addresses, and writes initial cell contents. Released cells are threaded into a LIFO free list stored in the BRAM itself, with the link held in the cell's data word. Address 0 is reserved as null and is never allocated.

---
 rtl/cell_alloc.sv | 173 +++++++++++++++++
 tb/tb_cell_alloc.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_alloc.sv
// cell_alloc: free-list cell allocator driving the write/read ports of a BRAM heap.
// Freed cells form a LIFO list threaded through the BRAM data words; address 0 is null.
module cell_alloc #(
    parameter int ADDR_SZ = 8,
    parameter int DATA_SZ = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_alloc,
    input  logic               i_free,
    input  logic [ADDR_SZ-1:0] i_addr,
    input  logic [DATA_SZ-1:0] i_data,
    output logic               o_ready,
    output logic               o_done,
    output logic               o_error,
    output logic [ADDR_SZ-1:0] o_addr,
    output logic [ADDR_SZ:0]   o_count,
    output logic               o_wr_en,
    output logic [ADDR_SZ-1:0] o_waddr,
    output logic [DATA_SZ-1:0] o_wdata,
    output logic               o_rd_en,
    output logic [ADDR_SZ-1:0] o_raddr,
    input  logic [DATA_SZ-1:0] i_rdata
);
    typedef enum logic [1:0] {IDLE, READ, LINK, WRITE} state_t;

    localparam logic [ADDR_SZ:0] ONE   = {{ADDR_SZ{1'b0}}, 1'b1};
    localparam logic [ADDR_SZ:0] CELLS = {1'b1, {ADDR_SZ{1'b0}}};

    state_t             state_q, state_d;
    logic [ADDR_SZ-1:0] free_head_q, free_head_d;
    logic [ADDR_SZ:0]   top_q, top_d;
    logic [ADDR_SZ:0]   count_q, count_d;
    logic [DATA_SZ-1:0] data_q, data_d;
    logic [ADDR_SZ-1:0] cell_q, cell_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [ADDR_SZ-1:0] addr_q, addr_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_SZ-1:0] waddr_q, waddr_d;
    logic [DATA_SZ-1:0] wdata_q, wdata_d;
    logic               rd_en_q, rd_en_d;
    logic [ADDR_SZ-1:0] raddr_q, raddr_d;
    logic               addr_ok;
    logic               unused_rdata;

    assign unused_rdata = ^i_rdata;
    assign addr_ok      = (i_addr != '0) && ({1'b0, i_addr} < top_q);

    always_comb begin
        state_d     = state_q;
        free_head_d = free_head_q;
        top_d       = top_q;
        count_d     = count_q;
        data_d      = data_q;
        cell_d      = cell_q;
        err_d       = err_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        addr_d      = addr_q;
        wr_en_d     = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        rd_en_d     = 1'b0;
        raddr_d     = raddr_q;
        case (state_q)
            IDLE: if (i_alloc || i_free) begin
                state_d = WRITE;
                err_d   = 1'b0;
                cell_d  = i_addr;
                if (i_alloc && !i_free) begin
                    if (free_head_q != '0) begin
                        rd_en_d = 1'b1;
                        raddr_d = free_head_q;
                        data_d  = i_data;
                        cell_d  = free_head_q;
                        state_d = READ;
                    end else if (top_q != CELLS) begin
                        wr_en_d = 1'b1;
                        waddr_d = top_q[ADDR_SZ-1:0];
                        wdata_d = i_data;
                        cell_d  = top_q[ADDR_SZ-1:0];
                        top_d   = top_q + ONE;
                        count_d = count_q + ONE;
                    end else begin
                        err_d  = 1'b1;
                        cell_d = '0;
                    end
                end else if (!addr_ok) begin
                    err_d = 1'b1;
                end else if (!i_alloc) begin
                    wr_en_d     = 1'b1;
                    waddr_d     = i_addr;
                    wdata_d     = DATA_SZ'(free_head_q);
                    free_head_d = i_addr;
                    count_d     = count_q - ONE;
                end else begin
                    // alloc+free on one cell: overwrite in place, list untouched
                    wr_en_d = 1'b1;
                    waddr_d = i_addr;
                    wdata_d = i_data;
                end
            end
            READ: state_d = LINK;
            LINK: begin
                free_head_d = i_rdata[ADDR_SZ-1:0];
                wr_en_d     = 1'b1;
                waddr_d     = cell_q;
                wdata_d     = data_q;
                count_d     = count_q + ONE;
                state_d     = WRITE;
            end
            default: begin
                done_d  = 1'b1;
                error_d = err_q;
                addr_d  = cell_q;
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            free_head_q <= '0;
            top_q       <= ONE;
            count_q     <= '0;
            data_q      <= '0;
            cell_q      <= '0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            addr_q      <= '0;
            wr_en_q     <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            rd_en_q     <= 1'b0;
            raddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            free_head_q <= free_head_d;
            top_q       <= top_d;
            count_q     <= count_d;
            data_q      <= data_d;
            cell_q      <= cell_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            error_q     <= error_d;
            addr_q      <= addr_d;
            wr_en_q     <= wr_en_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            rd_en_q     <= rd_en_d;
            raddr_q     <= raddr_d;
        end
    end

    assign o_ready = ready_q;
    assign o_done  = done_q;
    assign o_error = error_q;
    assign o_addr  = addr_q;
    assign o_count = count_q;
    assign o_wr_en = wr_en_q;
    assign o_waddr = waddr_q;
    assign o_wdata = wdata_q;
    assign o_rd_en = rd_en_q;
    assign o_raddr = raddr_q;
endmodule

// File: tb/tb_cell_alloc.sv
// tb_cell_alloc: directed scenario bench for cell_alloc with a 256x16 registered-read BRAM model.
module tb_cell_alloc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_alloc = 1'b0, i_free = 1'b0;
    logic [7:0]  i_addr = '0;
    logic [15:0] i_data = '0;
    logic        o_ready, o_done, o_error, o_wr_en, o_rd_en;
    logic [7:0]  o_addr, o_waddr, o_raddr;
    logic [8:0]  o_count;
    logic [15:0] o_wdata, rdata;
    logic [15:0] mem [256];
    int          checks = 0, errors = 0;
    logic [7:0]  ra;
    logic        re;
    int          lat, wrs;

    cell_alloc #(.ADDR_SZ(8), .DATA_SZ(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_alloc(i_alloc), .i_free(i_free),
        .i_addr(i_addr), .i_data(i_data), .o_ready(o_ready), .o_done(o_done),
        .o_error(o_error), .o_addr(o_addr), .o_count(o_count), .o_wr_en(o_wr_en),
        .o_waddr(o_waddr), .o_wdata(o_wdata), .o_rd_en(o_rd_en), .o_raddr(o_raddr),
        .i_rdata(rdata)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hDEAD;
        rdata = '0;
    end

    always @(posedge clk) begin
        if (o_wr_en) mem[o_waddr] <= o_wdata;
        if (o_rd_en) rdata <= mem[o_raddr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        i_alloc = 1'b0;
        i_free  = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // lat = edges from accept to o_done visible; wrs = cycles with o_wr_en seen
    task automatic req(input logic a, input logic f, input logic [7:0] ad, input logic [15:0] d,
                       output logic [7:0] oa, output logic oe, output int ol, output int ow);
        int n = 0;
        @(negedge clk);
        while (!o_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        i_alloc = a;
        i_free  = f;
        i_addr  = ad;
        i_data  = d;
        @(posedge clk);
        #1;
        i_alloc = 1'b0;
        i_free  = 1'b0;
        ow = int'(o_wr_en);
        ol = 0;
        while (!o_done && ol < 10) begin
            @(posedge clk);
            #1;
            ol++;
            if (o_wr_en) ow++;
        end
        oa = o_addr;
        oe = o_error;
    endtask

    task automatic setup3();
        do_reset();
        req(1, 0, 0, 16'h1111, ra, re, lat, wrs);
        req(1, 0, 0, 16'h2222, ra, re, lat, wrs);
        req(1, 0, 0, 16'h3333, ra, re, lat, wrs);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({o_ready, o_done, o_error, o_wr_en, o_rd_en} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 10000", {o_ready, o_done, o_error, o_wr_en, o_rd_en});
        end
        checks++;
        if (o_count !== 9'd0 || o_addr !== 8'd0) begin
            errors++;
            $display("FAIL reset_count got count=%0d addr=%0d exp 0/0", o_count, o_addr);
        end
    endtask

    task automatic test_bump();
        logic [15:0] d [3];
        d[0] = 16'h1111; d[1] = 16'h2222; d[2] = 16'h3333;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req(1, 0, 0, d[i], ra, re, lat, wrs);
            checks++;
            if (ra !== 8'(i + 1) || re !== 1'b0 || lat !== 1 || wrs !== 1) begin
                errors++;
                $display("FAIL bump%0d got addr=%0d err=%b lat=%0d wr=%0d exp %0d/0/1/1", i, ra, re, lat, wrs, i + 1);
            end
            checks++;
            if (mem[i + 1] !== d[i]) begin
                errors++;
                $display("FAIL bump_mem%0d got %h exp %h", i + 1, mem[i + 1], d[i]);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (o_done !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse got done=%b ready=%b exp 0/1", o_done, o_ready);
        end
        checks++;
        if (o_count !== 9'd3) begin
            errors++;
            $display("FAIL bump_count got %0d exp 3", o_count);
        end
    endtask

    task automatic test_pop();
        setup3();
        req(0, 1, 2, 0, ra, re, lat, wrs);
        checks++;
        if (ra !== 8'd2 || re !== 1'b0 || lat !== 1 || mem[2] !== 16'h0000 || o_count !== 9'd2) begin
            errors++;
            $display("FAIL free2 got addr=%0d err=%b lat=%0d mem=%h cnt=%0d exp 2/0/1/0000/2", ra, re, lat, mem[2], o_count);
        end
        req(1, 0, 0, 16'hAAAA, ra, re, lat, wrs);
        checks++;
        if (ra !== 8'd2 || re !== 1'b0 || lat !== 3 || mem[2] !== 16'hAAAA || o_count !== 9'd3) begin
            errors++;
            $display("FAIL pop2 got addr=%0d err=%b lat=%0d mem=%h cnt=%0d exp 2/0/3/aaaa/3", ra, re, lat, mem[2], o_count);
        end
        req(1, 0, 0, 16'h4444, ra, re, lat, wrs);
        checks++;
        if (ra !== 8'd4 || lat !== 1 || mem[4] !== 16'h4444) begin
            errors++;
            $display("FAIL after_pop got addr=%0d lat=%0d mem=%h exp 4/1/4444", ra, lat, mem[4]);
        end
    endtask

    task automatic test_lifo();
        setup3();
        req(0, 1, 1, 0, ra, re, lat, wrs);
        req(0, 1, 3, 0, ra, re, lat, wrs);
        checks++;
        if (mem[3] !== 16'h0001 || mem[1] !== 16'h0000 || o_count !== 9'd1) begin
            errors++;
            $display("FAIL lifo_links got m3=%h m1=%h cnt=%0d exp 0001/0000/1", mem[3], mem[1], o_count);
        end
        req(1, 0, 0, 16'hB0B0, ra, re, lat, wrs);
        checks++;
        if (ra !== 8'd3 || lat !== 3) begin
            errors++;
            $display("FAIL lifo_first got addr=%0d lat=%0d exp 3/3", ra, lat);
        end
        req(1, 0, 0, 16'hC0C0, ra, re, lat, wrs);
        checks++;
        if (ra !== 8'd1 || lat !== 3 || o_count !== 9'd3 || mem[1] !== 16'hC0C0) begin
            errors++;
            $display("FAIL lifo_second got addr=%0d lat=%0d cnt=%0d mem=%h exp 1/3/3/c0c0", ra, lat, o_count, mem[1]);
        end
        req(1, 0, 0, 16'hD0D0, ra, re, lat, wrs);
        checks++;
        if (ra !== 8'd4 || lat !== 1) begin
            errors++;
            $display("FAIL lifo_empty got addr=%0d lat=%0d exp 4/1", ra, lat);
        end
    endtask

    task automatic test_errors();
        logic [7:0]  bad [4];
        logic        both [4];
        setup3();
        req(1, 0, 0, 16'h4444, ra, re, lat, wrs);
        bad[0] = 8'd0; bad[1] = 8'd9; bad[2] = 8'd5; bad[3] = 8'd0;
        both[0] = 1'b0; both[1] = 1'b0; both[2] = 1'b0; both[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req(both[i], 1, bad[i], 16'hEEEE, ra, re, lat, wrs);
            checks++;
            if (re !== 1'b1 || wrs !== 0 || lat !== 1 || o_count !== 9'd4) begin
                errors++;
                $display("FAIL err_addr%0d got err=%b wr=%0d lat=%0d cnt=%0d exp 1/0/1/4", bad[i], re, wrs, lat, o_count);
            end
        end
        checks++;
        if (mem[0] === 16'hEEEE || mem[5] === 16'hEEEE || mem[9] === 16'hEEEE) begin
            errors++;
            $display("FAIL err_mem got m0=%h m5=%h m9=%h exp not eeee", mem[0], mem[5], mem[9]);
        end
        req(1, 0, 0, 16'h5555, ra, re, lat, wrs);
        checks++;
        if (ra !== 8'd5 || re !== 1'b0 || lat !== 1) begin
            errors++;
            $display("FAIL err_after got addr=%0d err=%b lat=%0d exp 5/0/1", ra, re, lat);
        end
    endtask

    task automatic test_full();
        int bad_cnt = 0;
        do_reset();
        for (int i = 1; i <= 255; i++) begin
            req(1, 0, 0, 16'(i), ra, re, lat, wrs);
            checks++;
            if (ra !== 8'(i) || re !== 1'b0) begin
                errors++;
                bad_cnt++;
                if (bad_cnt < 5) $display("FAIL full_alloc%0d got addr=%0d err=%b exp %0d/0", i, ra, re, i);
            end
        end
        checks++;
        if (o_count !== 9'd255) begin
            errors++;
            $display("FAIL full_count got %0d exp 255", o_count);
        end
        req(1, 0, 0, 16'hFFFF, ra, re, lat, wrs);
        checks++;
        if (re !== 1'b1 || wrs !== 0 || o_count !== 9'd255) begin
            errors++;
            $display("FAIL full_overflow got err=%b wr=%0d cnt=%0d exp 1/0/255", re, wrs, o_count);
        end
        req(0, 1, 17, 0, ra, re, lat, wrs);
        req(1, 0, 0, 16'h1717, ra, re, lat, wrs);
        checks++;
        if (ra !== 8'd17 || re !== 1'b0 || lat !== 3 || o_count !== 9'd255 || mem[17] !== 16'h1717) begin
            errors++;
            $display("FAIL full_reuse got addr=%0d err=%b lat=%0d cnt=%0d mem=%h exp 17/0/3/255/1717", ra, re, lat, o_count, mem[17]);
        end
    endtask

    task automatic test_both();
        setup3();
        req(1, 1, 2, 16'h5555, ra, re, lat, wrs);
        checks++;
        if (ra !== 8'd2 || re !== 1'b0 || lat !== 1 || mem[2] !== 16'h5555 || o_count !== 9'd3) begin
            errors++;
            $display("FAIL both got addr=%0d err=%b lat=%0d mem=%h cnt=%0d exp 2/0/1/5555/3", ra, re, lat, mem[2], o_count);
        end
        req(1, 0, 0, 16'h6666, ra, re, lat, wrs);
        checks++;
        if (ra !== 8'd4 || lat !== 1) begin
            errors++;
            $display("FAIL both_nolist got addr=%0d lat=%0d exp 4/1", ra, lat);
        end
    endtask

    task automatic test_reset_mid();
        setup3();
        req(0, 1, 2, 0, ra, re, lat, wrs);
        @(negedge clk);
        i_alloc = 1'b1;
        i_data  = 16'h7777;
        @(posedge clk);
        #1;
        i_alloc = 1'b0;
        checks++;
        if (o_rd_en !== 1'b1 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_read got rd=%b ready=%b exp 1/0", o_rd_en, o_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_ready !== 1'b1 || o_count !== 9'd0 || o_rd_en !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got ready=%b cnt=%0d rd=%b done=%b exp 1/0/0/0", o_ready, o_count, o_rd_en, o_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req(1, 0, 0, 16'h8888, ra, re, lat, wrs);
        checks++;
        if (ra !== 8'd1 || lat !== 1 || o_count !== 9'd1) begin
            errors++;
            $display("FAIL mid_after got addr=%0d lat=%0d cnt=%0d exp 1/1/1", ra, lat, o_count);
        end
    endtask

    initial begin
        test_reset();
        test_bump();
        test_pop();
        test_lifo();
        test_errors();
        test_full();
        test_both();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
